can_tx_scheduler: RTL and testbench

Transmit scheduler that shares the single transmit path of `custom_can_node` among `N_REQ` local message sources. It selects the pending frame with the highest CAN priority (lowest identifier), launches it through a start/ack handshake, and retries on lost arbitration or bus error. Per-requester retry budgets and a post-error backoff are enforced. It sits between application-side message producers and the CAN node's TX frame port.

---
 rtl/can_pkg.sv | 25 ++
 rtl/can_tx_scheduler_if.sv | 38 +++
 rtl/can_prio_select.sv | 33 +++
 rtl/can_tx_scheduler.sv | 143 ++++++++++++++
 tb/tb_can_tx_scheduler.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/can_pkg.sv
// Shared CAN constants, scheduler state encoding and small helpers.
// Pure declarations, no latency; no flow control of its own.
// Imported by the TX scheduler and the priority picker.
package can_pkg;

    localparam int CAN_ID_W    = 11;
    localparam int CAN_MAX_DLC = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_LAUNCH,
        ST_WAIT,
        ST_BACKOFF
    } sched_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [3:0] clamp_dlc(input logic [3:0] dlc);
        return (dlc > 4'(CAN_MAX_DLC)) ? 4'(CAN_MAX_DLC) : dlc;
    endfunction

endpackage

// File: rtl/can_tx_scheduler_if.sv
// Requester bundle plus node TX frame port shared by the scheduler and its environment.
// Wires only, no latency.
// Requesters hold req_valid until done/fail; the node paces launches through bus_idle.
interface can_tx_scheduler_if
    import can_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = CAN_ID_W
);
    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ*ID_W-1:0] req_id;
    logic [N_REQ*4-1:0]    req_dlc;
    logic [N_REQ*64-1:0]   req_data;
    logic [N_REQ-1:0]      req_done;
    logic [N_REQ-1:0]      req_fail;

    logic                  tx_start;
    logic [ID_W-1:0]       tx_id;
    logic [3:0]            tx_dlc;
    logic [63:0]           tx_data;
    logic                  bus_idle;
    logic                  tx_ack;
    logic                  tx_lost;
    logic                  tx_err;

    // Scheduler side
    modport slave (
        input  req_valid, req_id, req_dlc, req_data, bus_idle, tx_ack, tx_lost, tx_err,
        output req_done, req_fail, tx_start, tx_id, tx_dlc, tx_data
    );

    // Requesters plus node side
    modport master (
        output req_valid, req_id, req_dlc, req_data, bus_idle, tx_ack, tx_lost, tx_err,
        input  req_done, req_fail, tx_start, tx_id, tx_dlc, tx_data
    );

endinterface

// File: rtl/can_prio_select.sv
// Picks the valid entry with the lowest identifier, ties resolved to the lowest index.
// Combinational, zero latency.
// No flow control; found is low when nothing is valid.
module can_prio_select
    import can_pkg::*;
#(
    parameter int N     = 4,
    parameter int ID_W  = CAN_ID_W,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]      valid,
    input  logic [N*ID_W-1:0] id,
    output logic [IDX_W-1:0]  win_idx,
    output logic              found
);

    logic [ID_W-1:0] best_id;

    always_comb begin
        win_idx = '0;
        found   = 1'b0;
        best_id = '0;
        // Strict compare keeps the earlier index on equal identifiers
        for (int i = 0; i < N; i++) begin
            if (valid[i] && (!found || (id[i*ID_W +: ID_W] < best_id))) begin
                found   = 1'b1;
                best_id = id[i*ID_W +: ID_W];
                win_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/can_tx_scheduler.sv
// Shares one CAN TX path among N_REQ sources: lowest-ID arbitration, retry budget, error backoff.
// Latency: request seen in IDLE -> tx_start 3 edges later; done/fail one edge after the response.
// Backpressure: waits for bus_idle before selecting; requesters hold req_valid until done/fail.
module can_tx_scheduler
    import can_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int ID_W        = CAN_ID_W,
    parameter int MAX_RETRY   = 3,
    parameter int BACKOFF_CYC = 16,
    parameter int WDOG_CYC    = 4096
) (
    input  logic               CLK,
    input  logic               RESET,
    can_tx_scheduler_if.slave  bus
);

    localparam int IDX_W  = idx_width(N_REQ);
    localparam int WDOG_W = $clog2(WDOG_CYC + 1);
    localparam int BO_W   = $clog2(BACKOFF_CYC + 1);

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [3:0]      dlc;
        logic [63:0]     data;
    } frame_t;

    sched_state_t           state;
    logic [IDX_W-1:0]       cur_idx;
    frame_t                 cur_frame;
    logic [N_REQ-1:0][3:0]  retry_cnt;
    logic [WDOG_W-1:0]      wdog_cnt;
    logic [BO_W-1:0]        backoff_cnt;
    logic                   tx_start_q;
    logic [N_REQ-1:0]       req_done_q;
    logic [N_REQ-1:0]       req_fail_q;

    logic [IDX_W-1:0]       win_idx;
    logic                   win_found;
    frame_t                 win_frame;
    logic [3:0]             next_retry;
    logic                   wdog_expire;

    can_prio_select #(
        .N    (N_REQ),
        .ID_W (ID_W),
        .IDX_W(IDX_W)
    ) u_prio_select (
        .valid  (bus.req_valid),
        .id     (bus.req_id),
        .win_idx(win_idx),
        .found  (win_found)
    );

    always_comb begin
        win_frame.id   = bus.req_id[int'(win_idx)*ID_W +: ID_W];
        win_frame.dlc  = clamp_dlc(bus.req_dlc[int'(win_idx)*4 +: 4]);
        win_frame.data = bus.req_data[int'(win_idx)*64 +: 64];
    end

    assign next_retry  = retry_cnt[cur_idx] + 4'd1;
    assign wdog_expire = (wdog_cnt == WDOG_W'(WDOG_CYC - 1));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= ST_IDLE;
            cur_idx     <= '0;
            cur_frame   <= '0;
            retry_cnt   <= '0;
            wdog_cnt    <= '0;
            backoff_cnt <= '0;
            tx_start_q  <= 1'b0;
            req_done_q  <= '0;
            req_fail_q  <= '0;
        end else begin
            tx_start_q <= 1'b0;
            req_done_q <= '0;
            req_fail_q <= '0;

            case (state)
                ST_IDLE: begin
                    for (int i = 0; i < N_REQ; i++) begin
                        if (!bus.req_valid[i]) retry_cnt[i] <= '0;
                    end
                    if ((|bus.req_valid) && bus.bus_idle) state <= ST_SELECT;
                end

                ST_SELECT: begin
                    // Everyone may have withdrawn since IDLE; fall back rather than launch garbage
                    if (win_found) begin
                        cur_idx   <= win_idx;
                        cur_frame <= win_frame;
                        state     <= ST_LAUNCH;
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                ST_LAUNCH: begin
                    tx_start_q <= 1'b1;
                    wdog_cnt   <= '0;
                    state      <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (bus.tx_ack) begin
                        req_done_q[cur_idx] <= 1'b1;
                        retry_cnt[cur_idx]  <= '0;
                        state               <= ST_IDLE;
                    end else if (bus.tx_err || (!bus.tx_lost && wdog_expire)) begin
                        if (next_retry == 4'(MAX_RETRY)) begin
                            req_fail_q[cur_idx] <= 1'b1;
                            retry_cnt[cur_idx]  <= '0;
                        end else begin
                            retry_cnt[cur_idx]  <= next_retry;
                        end
                        backoff_cnt <= '0;
                        state       <= ST_BACKOFF;
                    end else if (bus.tx_lost) begin
                        state <= ST_IDLE;
                    end else begin
                        wdog_cnt <= wdog_cnt + 1'b1;
                    end
                end

                ST_BACKOFF: begin
                    if (backoff_cnt == BO_W'(BACKOFF_CYC - 1)) state <= ST_IDLE;
                    else backoff_cnt <= backoff_cnt + 1'b1;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.tx_start = tx_start_q;
    assign bus.tx_id    = cur_frame.id;
    assign bus.tx_dlc   = cur_frame.dlc;
    assign bus.tx_data  = cur_frame.data;
    assign bus.req_done = req_done_q;
    assign bus.req_fail = req_fail_q;

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Directed bench for can_tx_scheduler: latency, priority, ties, retry budget, lost arbitration, reset, watchdog.
module tb_can_tx_scheduler;
    import can_pkg::*;

    localparam int N_REQ       = 4;
    localparam int ID_W        = 11;
    localparam int MAX_RETRY   = 3;
    localparam int BACKOFF_CYC = 16;
    localparam int WDOG_CYC    = 64;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;
    always #5 CLK = ~CLK;

    can_tx_scheduler_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus ();

    can_tx_scheduler #(
        .N_REQ      (N_REQ),
        .ID_W       (ID_W),
        .MAX_RETRY  (MAX_RETRY),
        .BACKOFF_CYC(BACKOFF_CYC),
        .WDOG_CYC   (WDOG_CYC)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus)
    );

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    logic [N_REQ-1:0] done_seen;
    logic [N_REQ-1:0] fail_seen;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        done_seen = done_seen | bus.req_done;
        fail_seen = fail_seen | bus.req_fail;
    endtask

    task automatic set_req(input int i, input logic [10:0] id, input logic [3:0] dlc, input logic [63:0] data);
        bus.req_id[i*ID_W +: ID_W] = id;
        bus.req_dlc[i*4 +: 4]      = dlc;
        bus.req_data[i*64 +: 64]   = data;
    endtask

    // Ticks until tx_start is seen; an expired budget is reported as a failed check
    task automatic wait_start(input string tag, input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.tx_start !== 1'b1 && n < limit);
        check({tag, "_seen"}, 64'(bus.tx_start), 64'd1);
    endtask

    task automatic count_starts(input int cycles, output int k);
        k = 0;
        for (int c = 0; c < cycles; c++) begin
            tick();
            if (bus.tx_start === 1'b1) k++;
        end
    endtask

    task automatic respond(input int which);
        if (which == 0) bus.tx_ack = 1'b1;
        else if (which == 1) bus.tx_lost = 1'b1;
        else bus.tx_err = 1'b1;
        tick();
        bus.tx_ack  = 1'b0;
        bus.tx_lost = 1'b0;
        bus.tx_err  = 1'b0;
    endtask

    initial begin
        int n;
        int k;

        bus.req_valid = '0;
        bus.req_id    = '0;
        bus.req_dlc   = '0;
        bus.req_data  = '0;
        bus.bus_idle  = 1'b1;
        bus.tx_ack    = 1'b0;
        bus.tx_lost   = 1'b0;
        bus.tx_err    = 1'b0;
        done_seen     = '0;
        fail_seen     = '0;

        #1 RESET = 1'b1;
        #1;
        check("rst_tx_start", 64'(bus.tx_start), 64'd0);
        check("rst_tx_id",    64'(bus.tx_id),    64'd0);
        check("rst_tx_dlc",   64'(bus.tx_dlc),   64'd0);
        check("rst_tx_data",  bus.tx_data,       64'd0);
        check("rst_req_done", 64'(bus.req_done), 64'd0);
        check("rst_req_fail", 64'(bus.req_fail), 64'd0);
        check("rst_state",    64'(dut.state),    64'(ST_IDLE));
        check("rst_retry",    64'(dut.retry_cnt), 64'd0);
        tick();
        tick();
        RESET = 1'b0;

        // Responses outside WAIT are ignored
        respond(0);
        respond(2);
        count_starts(4, k);
        check("idle_resp_starts", 64'(k), 64'd0);
        check("idle_resp_done", 64'(done_seen), 64'd0);
        check("idle_resp_fail", 64'(fail_seen), 64'd0);

        // Single frame
        set_req(0, 11'h123, 4'd2, 64'hBEEF);
        bus.req_valid = 4'b0001;
        wait_start("t1_start", 10, n);
        check("t1_latency", 64'(n), 64'd3);
        check("t1_tx_id", 64'(bus.tx_id), 64'h123);
        check("t1_tx_dlc", 64'(bus.tx_dlc), 64'd2);
        check("t1_tx_data", bus.tx_data, 64'hBEEF);
        tick();
        check("t1_start_width", 64'(bus.tx_start), 64'd0);
        respond(0);
        check("t1_done", 64'(bus.req_done), 64'b0001);
        bus.req_valid = 4'b0000;
        tick();
        check("t1_done_width", 64'(bus.req_done), 64'd0);
        check("t1_tx_id_hold", 64'(bus.tx_id), 64'h123);
        count_starts(12, k);
        check("t1_no_restart", 64'(k), 64'd0);

        // Priority: lower identifier wins; oversized DLC is clamped
        set_req(1, 11'h100, 4'd3, 64'h1111);
        set_req(2, 11'h0F0, 4'hF, 64'h2222);
        bus.req_valid = 4'b0110;
        wait_start("t2_first", 10, n);
        check("t2_first_id", 64'(bus.tx_id), 64'h0F0);
        check("t2_dlc_clamp", 64'(bus.tx_dlc), 64'd8);
        respond(0);
        check("t2_first_done", 64'(bus.req_done), 64'b0100);
        bus.req_valid = 4'b0010;
        wait_start("t2_second", 10, n);
        check("t2_b2b_gap", 64'(n), 64'd3);
        check("t2_second_id", 64'(bus.tx_id), 64'h100);
        respond(0);
        check("t2_second_done", 64'(bus.req_done), 64'b0010);
        bus.req_valid = 4'b0000;

        // Tie on identifier: lower index first
        set_req(0, 11'h050, 4'd1, 64'hA0);
        set_req(3, 11'h050, 4'd1, 64'hA3);
        bus.req_valid = 4'b1001;
        wait_start("t3_first", 10, n);
        check("t3_first_data", bus.tx_data, 64'hA0);
        respond(0);
        check("t3_first_done", 64'(bus.req_done), 64'b0001);
        bus.req_valid = 4'b1000;
        wait_start("t3_second", 10, n);
        check("t3_second_data", bus.tx_data, 64'hA3);
        respond(0);
        check("t3_second_done", 64'(bus.req_done), 64'b1000);
        bus.req_valid = 4'b0000;

        // Error on every attempt: retry budget, backoff spacing, fail pulse
        done_seen = '0;
        set_req(0, 11'h200, 4'd1, 64'h1);
        bus.req_valid = 4'b0001;
        for (int a = 0; a < MAX_RETRY; a++) begin
            wait_start($sformatf("t4_start%0d", a), 60, n);
            check($sformatf("t4_gap%0d", a), 64'(n), (a == 0) ? 64'd3 : 64'(BACKOFF_CYC + 3));
            respond(2);
            check($sformatf("t4_fail%0d", a), 64'(bus.req_fail),
                  (a == MAX_RETRY - 1) ? 64'b0001 : 64'd0);
            check($sformatf("t4_retry%0d", a), 64'(dut.retry_cnt[0]),
                  (a == MAX_RETRY - 1) ? 64'd0 : 64'(a + 1));
        end
        bus.req_valid = 4'b0000;
        tick();
        check("t4_fail_width", 64'(bus.req_fail), 64'd0);
        count_starts(BACKOFF_CYC + 20, k);
        check("t4_no_fourth", 64'(k), 64'd0);
        check("t4_no_done", 64'(done_seen), 64'd0);

        // Lost arbitration twice, then ack: no backoff, retry untouched
        set_req(1, 11'h010, 4'd3, 64'h77);
        bus.req_valid = 4'b0010;
        for (int a = 0; a < 3; a++) begin
            wait_start($sformatf("t5_start%0d", a), 10, n);
            check($sformatf("t5_gap%0d", a), 64'(n), 64'd3);
            if (a < 2) begin
                respond(1);
                check($sformatf("t5_retry%0d", a), 64'(dut.retry_cnt[1]), 64'd0);
                check($sformatf("t5_nodone%0d", a), 64'(bus.req_done), 64'd0);
            end else begin
                respond(0);
                check("t5_done", 64'(bus.req_done), 64'b0010);
            end
        end
        bus.req_valid = 4'b0000;

        // Reset mid-WAIT, relaunch, then watchdog expiry
        set_req(2, 11'h321, 4'd4, 64'h55);
        bus.req_valid = 4'b0100;
        wait_start("t6_start", 10, n);
        tick();
        RESET = 1'b1;
        #1;
        check("t6_rst_tx_id", 64'(bus.tx_id), 64'd0);
        check("t6_rst_tx_dlc", 64'(bus.tx_dlc), 64'd0);
        check("t6_rst_tx_data", bus.tx_data, 64'd0);
        check("t6_rst_tx_start", 64'(bus.tx_start), 64'd0);
        check("t6_rst_done", 64'(bus.req_done), 64'd0);
        check("t6_rst_fail", 64'(bus.req_fail), 64'd0);
        tick();
        tick();
        RESET = 1'b0;
        done_seen = '0;
        fail_seen = '0;
        wait_start("t6_relaunch", 10, n);
        check("t6_relaunch_lat", 64'(n), 64'd3);
        check("t6_relaunch_id", 64'(bus.tx_id), 64'h321);
        check("t6_no_stale_done", 64'(done_seen), 64'd0);
        wait_start("t7_wdog", WDOG_CYC + BACKOFF_CYC + 20, n);
        check("t7_wdog_gap", 64'(n), 64'(WDOG_CYC + BACKOFF_CYC + 3));
        check("t7_retry", 64'(dut.retry_cnt[2]), 64'd1);
        check("t7_no_fail", 64'(fail_seen), 64'd0);
        respond(0);
        check("t7_done", 64'(bus.req_done), 64'b0100);
        bus.req_valid = 4'b0000;
        tick();
        tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
